// File: rtl/alu_arb_pkg.sv
// Shared constants for the two-requester ALU arbiter: opcodes, FSM states, flag bit positions.
// Optional divide-by-zero reporting is enabled by defining ALU_ARB_DIVZERO_EN.
package alu_arb_pkg;

  localparam int FLG_W = 5;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam int FLG_ZERO   = 4;
  localparam int FLG_CARRY  = 3;
  localparam int FLG_SIGN   = 2;
  localparam int FLG_PARITY = 1;
  localparam int FLG_OVF    = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_exec.sv
// Combinational W-bit add/sub/mul/div unit producing result, flags and divide-by-zero error.
// Macro ALU_ARB_DIVZERO_EN: div by zero yields all-ones with err=1; otherwise it yields 0.
module alu_exec
  import alu_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [1:0]       op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [W-1:0]     out,
  output logic [FLG_W-1:0] flags,
  output logic             err
);

  logic [W:0] r;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    r   = '0;
    err = 1'b0;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_MUL:  r = {1'b0, a} * {1'b0, b};
      default: begin
        if (b == '0) begin
`ifdef ALU_ARB_DIVZERO_EN
          r   = {1'b0, {W{1'b1}}};
          err = 1'b1;
`else
          r   = '0;
`endif
        end else begin
          r = {1'b0, a / b};
        end
      end
    endcase
  end

  assign out = r[W-1:0];

  // Overflow uses the signed-add rule for every opcode, keyed on the operand and result sign bits.
  always_comb begin
    flags             = '0;
    flags[FLG_ZERO]   = ~|out;
    flags[FLG_CARRY]  = r[W];
    flags[FLG_SIGN]   = out[W-1];
    flags[FLG_PARITY] = ~^out;
    flags[FLG_OVF]    = (a[W-1] & b[W-1] & ~out[W-1]) | (~a[W-1] & ~b[W-1] & out[W-1]);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu_exec between two requesters, with a valid/ready response.
// Macro ALU_ARB_DIVZERO_EN (in alu_exec) turns on divide-by-zero reporting on resp_err.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [W-1:0]     a0,
  input  logic [W-1:0]     b0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [W-1:0]     a1,
  input  logic [W-1:0]     b1,
  output logic             gnt1,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [W-1:0]     resp_out,
  output logic [FLG_W-1:0] resp_flags,
  output logic             resp_err
);

  state_t           state, state_nxt;
  logic             last;
  logic             win;
  logic             any_req;
  logic [1:0]       op_q;
  logic [W-1:0]     a_q, b_q;
  logic             id_q;
  logic [W-1:0]     ex_out;
  logic [FLG_W-1:0] ex_flags;
  logic             ex_err;

  assign any_req = req0 | req1;
  // On contention the requester that did not win last time goes first.
  assign win     = (req0 & req1) ? ~last : req1;

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous, active-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grants are suppressed while reset is held so every output reads 0 during reset.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && !reset) begin
          gnt0 = ~win;
          gnt1 = win;
        end
      end
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last       <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      resp_id    <= 1'b0;
      resp_out   <= '0;
      resp_flags <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        last <= win;
        id_q <= win;
        op_q <= win ? op1 : op0;
        a_q  <= win ? a1 : a0;
        b_q  <= win ? b1 : b0;
      end
      if (state == EXEC) begin
        resp_id    <= id_q;
        resp_out   <= ex_out;
        resp_flags <= ex_flags;
        resp_err   <= ex_err;
      end
    end
  end

  alu_exec #(.W(W)) u_exec (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .out   (ex_out),
    .flags (ex_flags),
    .err   (ex_err)
  );

endmodule
